// File: rtl/keccak_squeeze_out.sv
// Squeeze-side reader of a permuted Keccak state: streams the rate lanes as 64-bit words
// and requests further permutations until the requested output length has been delivered.
module keccak_squeeze_out #(
    parameter int LEN_W    = 16,
    parameter int MAX_RATE = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [4:0]       rate_lanes_i,
    input  logic [LEN_W-1:0] out_len_i,
    input  logic [1599:0]    state_i,
    input  logic             state_valid_i,
    output logic             state_ready_o,
    output logic             perm_req_o,
    output logic [63:0]      dout_o,
    output logic             dout_valid_o,
    input  logic             dout_ready_i,
    output logic             dout_last_o,
    output logic             busy_o,
    output logic             err_o
);

    typedef enum logic [1:0] {IDLE, WAIT, EMIT, REQ} fsm_t;

    localparam logic [4:0]       MAX_RATE_L = 5'(MAX_RATE);
    localparam logic [LEN_W-1:0] ONE        = LEN_W'(1);

    fsm_t             fsm, fsm_n;
    logic [1599:0]    cap, cap_n;
    logic [4:0]       rate, rate_n;
    logic [4:0]       lane_idx, lane_n;
    logic [LEN_W-1:0] rem, rem_n;
    logic [63:0]      dout_n;
    logic             dout_valid_n, dout_last_n, state_ready_n, perm_req_n, busy_n, err_n;

    logic             start_bad, start_ok, cap_hs, out_hs;
    logic [LEN_W-1:0] rem_dec;
    logic [4:0]       lane_inc;

    assign start_bad = start_i && (rate_lanes_i == '0 || rate_lanes_i > MAX_RATE_L);
    assign start_ok  = start_i && !start_bad && (out_len_i != '0);
    assign cap_hs    = (fsm == WAIT) && state_valid_i && state_ready_o;
    assign out_hs    = (fsm == EMIT) && dout_valid_o && dout_ready_i;
    assign rem_dec   = rem - ONE;
    assign lane_inc  = lane_idx + 5'd1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) fsm <= IDLE;
        else        fsm <= fsm_n;
    end

    // NOTE: every combinational output gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        fsm_n = fsm;
        case (fsm)
            IDLE: if (start_ok) fsm_n = WAIT;
            WAIT: if (cap_hs) fsm_n = EMIT;
            EMIT: begin
                if (out_hs) begin
                    if (rem_dec == '0)         fsm_n = IDLE;
                    else if (lane_inc == rate) fsm_n = REQ;
                end
            end
            REQ:     fsm_n = WAIT;
            default: fsm_n = IDLE;
        endcase
    end

    // Next values for the datapath and for every (registered) output.
    always_comb begin
        cap_n        = cap;
        rate_n       = rate;
        lane_n       = lane_idx;
        rem_n        = rem;
        dout_n       = dout_o;
        dout_valid_n = dout_valid_o;
        dout_last_n  = dout_last_o;
        perm_req_n   = 1'b0;
        err_n        = 1'b0;
        case (fsm)
            IDLE: begin
                err_n = start_bad;
                if (start_ok) begin
                    rate_n = rate_lanes_i;
                    rem_n  = out_len_i;
                    lane_n = '0;
                end
            end
            WAIT: begin
                if (cap_hs) begin
                    cap_n        = state_i;
                    dout_n       = state_i[{lane_idx, 6'b0} +: 64];
                    dout_valid_n = 1'b1;
                    dout_last_n  = (rem == ONE);
                end
            end
            EMIT: begin
                if (out_hs) begin
                    rem_n  = rem_dec;
                    lane_n = lane_inc;
                    if (rem_dec == '0) begin
                        dout_valid_n = 1'b0;
                        dout_last_n  = 1'b0;
                    end else if (lane_inc == rate) begin
                        // Rate exhausted but output still owed: squeeze another block.
                        lane_n       = '0;
                        dout_valid_n = 1'b0;
                        dout_last_n  = 1'b0;
                        perm_req_n   = 1'b1;
                    end else begin
                        dout_n      = cap[{lane_inc, 6'b0} +: 64];
                        dout_last_n = (rem_dec == ONE);
                    end
                end
            end
            default: ;
        endcase
        state_ready_n = (fsm_n == WAIT);
        busy_n        = (fsm_n != IDLE);
    end

    // NOTE: the 1600-bit capture register is reset deliberately so a job aborted by
    // reset can never leak stale digest material into the next one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap           <= '0;
            rate          <= '0;
            lane_idx      <= '0;
            rem           <= '0;
            dout_o        <= '0;
            dout_valid_o  <= 1'b0;
            dout_last_o   <= 1'b0;
            state_ready_o <= 1'b0;
            perm_req_o    <= 1'b0;
            busy_o        <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            cap           <= cap_n;
            rate          <= rate_n;
            lane_idx      <= lane_n;
            rem           <= rem_n;
            dout_o        <= dout_n;
            dout_valid_o  <= dout_valid_n;
            dout_last_o   <= dout_last_n;
            state_ready_o <= state_ready_n;
            perm_req_o    <= perm_req_n;
            busy_o        <= busy_n;
            err_o         <= err_n;
        end
    end

endmodule

// File: tb/tb_keccak_squeeze_out.sv
// Testbench for keccak_squeeze_out: directed and randomized squeeze jobs checked against
// a word-queue model built from the lane-order and block-count rules.
module tb_keccak_squeeze_out;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_i;
    logic [4:0]       rate_lanes_i;
    logic [LEN_W-1:0] out_len_i;
    logic [1599:0]    state_i;
    logic             state_valid_i;
    logic             state_ready_o;
    logic             perm_req_o;
    logic [63:0]      dout_o;
    logic             dout_valid_o;
    logic             dout_ready_i;
    logic             dout_last_o;
    logic             busy_o;
    logic             err_o;

    int checks = 0;
    int errors = 0;

    keccak_squeeze_out #(.LEN_W(LEN_W), .MAX_RATE(21)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .rate_lanes_i  (rate_lanes_i),
        .out_len_i     (out_len_i),
        .state_i       (state_i),
        .state_valid_i (state_valid_i),
        .state_ready_o (state_ready_o),
        .perm_req_o    (perm_req_o),
        .dout_o        (dout_o),
        .dout_valid_o  (dout_valid_o),
        .dout_ready_i  (dout_ready_i),
        .dout_last_o   (dout_last_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_dout"}, dout_o, 64'd0);
        check({tag, "_ctl"}, {58'd0, dout_valid_o, dout_last_o, perm_req_o, busy_o, err_o, state_ready_o}, 64'd0);
    endtask

    // Builds a [y][x][z] state where lane i = y*5+x carries vals[i].
    function automatic logic [1599:0] build_state(input logic [63:0] vals [25]);
        logic [4:0][4:0][63:0] st;
        for (int i = 0; i < 25; i++) st[i / 5][i % 5] = vals[i];
        return st;
    endfunction

    // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random. abort_at < 0 means run to completion.
    task automatic run_job(input int r, input int len, input int rmode, input bit rnd_lanes,
                           input int abort_at, input bit mid_start);
        logic [63:0] expq [$];
        logic [63:0] vals [25];
        bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int          pushed = 0, popped = 0, blk = 0, cyc = 0, vcnt = 0;
        int          budget = 40 * len + 200;
        bit          exp_req = 0, exp_rdy = 0, exp_dv = 0, mid_done = 0, rdy;

        start_i = 1'b1; rate_lanes_i = 5'(r); out_len_i = LEN_W'(len);
        @(negedge clk);
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1);
        check("ready_after_start", state_ready_o, 1);

        while (popped < len && cyc < budget) begin
            cyc++;
            if (abort_at >= 0 && popped == abort_at) begin
                rst_n = 1'b0; dout_ready_i = 1'b0; state_valid_i = 1'b0; start_i = 1'b0;
                @(negedge clk);
                check_idle_outputs("reset_mid_job");
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            check("perm_req_timing", perm_req_o, exp_req);
            if (exp_rdy) check("ready_after_req", state_ready_o, 1);
            if (exp_dv)  check("first_word_latency", dout_valid_o, 1);
            exp_req = 0; exp_rdy = perm_req_o; exp_dv = 0;
            state_valid_i = 1'b0; dout_ready_i = 1'b0; start_i = 1'b0;

            if (state_ready_o) begin
                for (int i = 0; i < 25; i++)
                    vals[i] = rnd_lanes ? {$urandom, $urandom} : 64'(i + 64 * blk);
                state_i = build_state(vals);
                state_valid_i = 1'b1;
                for (int i = 0; i < r && pushed < len; i++) begin
                    expq.push_back(vals[i]);
                    pushed++;
                end
                blk++;
                exp_dv = 1;
            end else if (rmode == 2 && $urandom_range(0, 3) == 0) begin
                // Garbage outside WAIT must be ignored.
                for (int i = 0; i < 25; i++) vals[i] = {$urandom, $urandom};
                state_i = build_state(vals);
                state_valid_i = 1'b1;
            end

            if (dout_valid_o) begin
                check("word_pending", 64'(expq.size() != 0), 1);
                if (expq.size() != 0) check("dout", dout_o, expq[0]);
                check("last", dout_last_o, 64'(popped == len - 1));
                case (rmode)
                    0:       rdy = 1'b1;
                    1:       rdy = pat[vcnt % 4];
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                vcnt++;
                dout_ready_i = rdy;
                if (rdy && expq.size() != 0) begin
                    void'(expq.pop_front());
                    popped++;
                    if (popped < len && popped % r == 0) exp_req = 1;
                end
            end

            if (mid_start && !mid_done && popped >= 2) begin
                start_i = 1'b1; rate_lanes_i = 5'd5; out_len_i = LEN_W'(3);
                mid_done = 1;
            end
            @(negedge clk);
        end

        dout_ready_i = 1'b0; state_valid_i = 1'b0; start_i = 1'b0;
        check("words_delivered", popped, len);
        check("valid_drops", dout_valid_o, 0);
        check("busy_drops", busy_o, 0);
        check("no_req_after_final", perm_req_o, 0);
        check("blocks_used", blk, (len + r - 1) / r);
        @(negedge clk);
    endtask

    task automatic err_start(input int r, input int len, input bit exp_err);
        start_i = 1'b1; rate_lanes_i = 5'(r); out_len_i = LEN_W'(len);
        @(negedge clk);
        start_i = 1'b0;
        check("err_pulse", err_o, 64'(exp_err));
        check("err_not_busy", busy_o, 0);
        check("err_no_ready", state_ready_o, 0);
        @(negedge clk);
        check("err_one_cycle", err_o, 0);
        check("err_still_idle", busy_o, 0);
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; rate_lanes_i = '0; out_len_i = '0;
        state_i = '0; state_valid_i = 1'b0; dout_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_job(17, 4, 0, 0, -1, 0);          // SHA3-256 short digest
        run_job(21, 25, 0, 0, -1, 0);         // SHAKE128 spanning two blocks
        run_job(17, 4, 1, 0, -1, 0);          // backpressure
        run_job(17, 17, 0, 0, -1, 0);         // exact multiple of rate
        run_job(9, 27, 1, 1, -1, 0);          // three full blocks, no trailing request
        err_start(0, 5, 1);                   // illegal rates
        err_start(22, 5, 1);
        err_start(17, 0, 0);                  // zero length: silently ignored
        run_job(13, 10, 0, 0, -1, 1);         // start while busy is ignored
        run_job(21, 25, 0, 0, 5, 0);          // reset after five words
        run_job(21, 25, 0, 0, -1, 0);         // clean restart from lane 0
        run_job(9, 65535, 2, 1, 30, 0);       // maximum length, abort after 30 words

        for (int j = 0; j < 6; j++)
            run_job($urandom_range(1, 21), $urandom_range(1, 60), 2, 1, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
